arb_req_frontend: RTL and testbench

ARB_REQ_FRONTEND -- requirements
Module: arb_req_frontend

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_req_fifo.sv | 52 +++++
 rtl/arb_req_frontend.sv | 76 +++++++
 tb/tb_arb_req_frontend.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the two-requester arbitration front end.
package arb_pkg;
  localparam int REQ_N = 2;
  localparam int ID_W  = $clog2(REQ_N);

  localparam int ERR_PUSH_FULL   = 0;
  localparam int ERR_GRANT_EMPTY = 1;
  localparam int ERR_MULTI_GRANT = 2;
  localparam int ERR_W           = 3;

  typedef logic [ERR_W-1:0] err_flags_t;
endpackage

// File: rtl/arb_req_fifo.sv
// Per-requester FIFO: head is visible combinationally, and a pop advances it on the edge.
// A push while full is dropped internally. full/empty come straight from the registered count.
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_en;
  logic              rd_en;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign wr_en     = push && !full;
  assign rd_en     = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/arb_req_frontend.sv
// Queues per-requester pushes and pops the granted head onto a registered output one cycle after the grant.
// in_ready drops only when a queue is full, and it ignores a same-cycle pop. Bad pushes or grants set sticky flags.
module arb_req_frontend
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_N-1:0]        in_valid,
  input  logic [REQ_N*DATA_W-1:0] in_data,
  output logic [REQ_N-1:0]        in_ready,
  output logic [REQ_N-1:0]        request,
  input  logic [REQ_N-1:0]        grant,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id,
  output logic [DATA_W-1:0]       out_data,
  output err_flags_t              err_flags
);
  logic [DATA_W-1:0] head [REQ_N];
  logic [REQ_N-1:0]  full;
  logic [REQ_N-1:0]  empty;
  logic [REQ_N-1:0]  pop;
  logic              multi_grant;
  err_flags_t        err_now;

  assign multi_grant = (grant & (grant - 1'b1)) != '0;

  for (genvar i = 0; i < REQ_N; i++) begin : g_q
    // A pop requires an exact one-hot grant; a multi-hot grant pops nothing.
    assign pop[i] = (grant == (REQ_N'(1) << i)) && !empty[i];

    arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head_data (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign in_ready = ~full;
  assign request  = ~empty;

  always_comb begin
    err_now                  = '0;
    err_now[ERR_PUSH_FULL]   = |(in_valid & full);
    err_now[ERR_GRANT_EMPTY] = |(grant & empty);
    err_now[ERR_MULTI_GRANT] = multi_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      err_flags <= '0;
    end else begin
      out_valid <= |pop;
      for (int i = 0; i < REQ_N; i++) begin
        if (pop[i]) begin
          out_id   <= ID_W'(i);
          out_data <= head[i];
        end
      end
      err_flags <= err_flags | err_now;
    end
  end
endmodule

// File: tb/tb_arb_req_frontend.sv
// Random and directed bench for arb_req_frontend, checked against a queue-based reference model and an output scoreboard.
module tb_arb_req_frontend;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    in_valid = '0;
  logic [15:0]   in_data = '0;
  logic [1:0]    in_ready;
  logic [1:0]    request;
  logic [1:0]    grant = '0;
  logic          out_valid;
  logic          out_id;
  logic [7:0]    out_data;
  logic [2:0]    err_flags;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] mq [2][$];
  logic [8:0] sb [$];
  logic       m_ov   = 1'b0;
  logic       m_id   = 1'b0;
  logic [7:0] m_data = '0;
  logic [2:0] m_err  = '0;

  arb_req_frontend #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .request(request), .grant(grant),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_request();
    m_request = {mq[1].size() != 0, mq[0].size() != 0};
  endfunction

  function automatic logic [1:0] m_ready();
    m_ready = {mq[1].size() < DEPTH, mq[0].size() < DEPTH};
  endfunction

  task automatic check_state();
    chk("request", int'(request), int'(m_request()));
    chk("in_ready", int'(in_ready), int'(m_ready()));
    chk("err_flags", int'(err_flags), int'(m_err));
    chk("out_valid", int'(out_valid), int'(m_ov));
    if (!m_ov) begin
      chk("out_id_hold", int'(out_id), int'(m_id));
      chk("out_data_hold", int'(out_data), int'(m_data));
    end
  endtask

  // Apply one clock edge's worth of queue rules to the model.
  task automatic model_step(input logic [1:0] v, input logic [15:0] d, input logic [1:0] g);
    int         sz [2];
    logic [7:0] x;
    for (int i = 0; i < 2; i++) sz[i] = mq[i].size();
    m_ov = 1'b0;
    if (g == 2'b11) m_err[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (v[i] && sz[i] == DEPTH) m_err[0] = 1'b1;
      if (g[i] && sz[i] == 0) m_err[1] = 1'b1;
      if (g == (i == 0 ? 2'b01 : 2'b10) && sz[i] != 0) begin
        x      = mq[i].pop_front();
        m_ov   = 1'b1;
        m_id   = 1'(i);
        m_data = x;
        sb.push_back({1'(i), x});
      end
      if (v[i] && sz[i] < DEPTH) mq[i].push_back(d[i*8 +: 8]);
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic [15:0] d, input logic [1:0] g);
    @(negedge clk);
    check_state();
    in_valid = v;
    in_data  = d;
    grant    = g;
    model_step(v, d, g);
  endtask

  task automatic do_reset();
    cycle(2'b00, 16'h0, 2'b00);
    cycle(2'b00, 16'h0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_request", int'(request), 0);
    chk("rst_in_ready", int'(in_ready), 3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_err", int'(err_flags), 0);
    mq[0].delete();
    mq[1].delete();
    m_ov = 1'b0; m_id = 1'b0; m_data = '0; m_err = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected pop.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_out_id", int'(out_id), int'(e[8]));
          chk("sb_out_data", int'(out_data), int'(e[7:0]));
        end
      end
    end
  end

  initial begin
    logic [1:0] v, g;
    logic [15:0] d;
    int r;
    #3;
    chk("init_request", int'(request), 0);
    chk("init_in_ready", int'(in_ready), 3);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_err", int'(err_flags), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single push then grant on queue 0
    cycle(2'b01, 16'h00A5, 2'b00);
    cycle(2'b00, 16'h0, 2'b01);
    cycle(2'b00, 16'h0, 2'b00);
    cycle(2'b00, 16'h0, 2'b00);

    // Fill queue 1, overflow, drain in order
    for (int k = 1; k <= 5; k++) cycle(2'b10, 16'(k) << 8, 2'b00);
    for (int k = 0; k < 4; k++) cycle(2'b00, 16'h0, 2'b10);
    cycle(2'b00, 16'h0, 2'b00);
    do_reset();

    // Multi-hot grant with both queues occupied
    cycle(2'b11, 16'h2211, 2'b00);
    cycle(2'b00, 16'h0, 2'b11);
    cycle(2'b00, 16'h0, 2'b00);
    cycle(2'b00, 16'h0, 2'b01);
    cycle(2'b00, 16'h0, 2'b10);
    do_reset();

    // Full queue 0: push and grant together
    for (int k = 0; k < 4; k++) cycle(2'b01, 16'(8'h30 + k), 2'b00);
    cycle(2'b01, 16'h00EE, 2'b01);
    cycle(2'b00, 16'h0, 2'b00);
    do_reset();

    // Pointer wrap through queue 0
    for (int k = 0; k < 10; k++) cycle(2'b01, 16'(8'h50 + k), (k > 0) ? 2'b01 : 2'b00);
    cycle(2'b00, 16'h0, 2'b01);
    cycle(2'b00, 16'h0, 2'b00);

    // Reset with entries queued, then grant to the now-empty queue
    cycle(2'b01, 16'h0077, 2'b00);
    cycle(2'b01, 16'h0078, 2'b00);
    do_reset();
    cycle(2'b00, 16'h0, 2'b01);
    cycle(2'b00, 16'h0, 2'b00);
    cycle(2'b00, 16'h0, 2'b00);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      v = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      r = $urandom_range(0, 9);
      g = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cycle(v, d, g);
      if (n % 500 == 499) do_reset();
    end

    cycle(2'b00, 16'h0, 2'b00);
    cycle(2'b00, 16'h0, 2'b00);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
